// File: rtl/sdram_arb_pkg.sv
// Shared types for the SDRAM port arbiter: requester identities and FSM states.
package sdram_arb_pkg;

    typedef enum logic [1:0] {
        PORT_NONE = 2'd0,
        PORT_VID  = 2'd1,
        PORT_CPU  = 2'd2,
        PORT_JTAG = 2'd3
    } port_id_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } arb_state_t;

    // The round-robin pointer always moves to the general port that was not just served.
    function automatic port_id_t other_general(input port_id_t p);
        return (p == PORT_CPU) ? PORT_JTAG : PORT_CPU;
    endfunction

endpackage

// File: rtl/sdram_arb_pick.sv
// Combinational winner selection: bounded video priority, CPU/JTAG round-robin.
module sdram_arb_pick
    import sdram_arb_pkg::*;
#(
    parameter int VIDEO_MAX = 4,
    parameter int STREAK_W  = $clog2(VIDEO_MAX + 1)
) (
    input  logic                vid_req,
    input  logic                cpu_req,
    input  logic                jtag_req,
    input  logic [STREAK_W-1:0] streak,
    input  port_id_t            rr_ptr,
    output port_id_t            winner
);

    logic gen_pending;

    assign gen_pending = cpu_req | jtag_req;

    always_comb begin
        winner = PORT_NONE;
        if (vid_req && (!gen_pending || (streak < STREAK_W'(VIDEO_MAX)))) begin
            winner = PORT_VID;
        end else if (cpu_req && jtag_req) begin
            winner = rr_ptr;
        end else if (cpu_req) begin
            winner = PORT_CPU;
        end else if (jtag_req) begin
            winner = PORT_JTAG;
        end
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Shares one SDRAM controller req/ack port between video, CPU and JTAG; one transaction in flight.
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 24,
    parameter int DATA_WIDTH = 16,
    parameter int VIDEO_MAX  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  vid_req,
    input  logic [ADDR_WIDTH-1:0] vid_addr,
    output logic                  vid_ack,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    input  logic [1:0]            cpu_bytesel,
    output logic                  cpu_ack,
    input  logic                  jtag_req,
    input  logic                  jtag_we,
    input  logic [ADDR_WIDTH-1:0] jtag_addr,
    input  logic [DATA_WIDTH-1:0] jtag_wdata,
    input  logic [1:0]            jtag_bytesel,
    output logic                  jtag_ack,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [1:0]            mem_dqm,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [1:0]            grant_id,
    output logic                  protocol_err
);

    localparam int STREAK_W = $clog2(VIDEO_MAX + 1);

    arb_state_t          state;
    arb_state_t          state_next;
    port_id_t            winner;
    port_id_t            rr_ptr;
    port_id_t            grant;
    logic [STREAK_W-1:0] streak;
    logic                gen_pending;

    assign gen_pending = cpu_req | jtag_req;

    sdram_arb_pick #(
        .VIDEO_MAX(VIDEO_MAX),
        .STREAK_W (STREAK_W)
    ) u_pick (
        .vid_req (vid_req),
        .cpu_req (cpu_req),
        .jtag_req(jtag_req),
        .streak  (streak),
        .rr_ptr  (rr_ptr),
        .winner  (winner)
    );

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (winner != PORT_NONE) state_next = ISSUE;
            ISSUE:   if (mem_ack) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs decode from registered state so reset forces them low without waiting for a clock.
    assign mem_req  = (state == ISSUE);
    assign vid_ack  = (state == RESP) && (grant == PORT_VID);
    assign cpu_ack  = (state == RESP) && (grant == PORT_CPU);
    assign jtag_ack = (state == RESP) && (grant == PORT_JTAG);
    assign grant_id = grant;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            grant        <= PORT_NONE;
            rr_ptr       <= PORT_CPU;
            streak       <= '0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_dqm      <= 2'b00;
            rdata        <= '0;
            protocol_err <= 1'b0;
        end else begin
            state <= state_next;
            if (mem_ack && (state != ISSUE)) begin
                protocol_err <= 1'b1;
            end
            case (state)
                IDLE: begin
                    grant <= winner;
                    case (winner)
                        PORT_VID: begin
                            mem_we    <= 1'b0;
                            mem_addr  <= vid_addr;
                            mem_wdata <= '0;
                            mem_dqm   <= 2'b00;
                            if (!gen_pending) begin
                                streak <= '0;
                            end else if (streak != STREAK_W'(VIDEO_MAX)) begin
                                streak <= streak + STREAK_W'(1);
                            end
                        end
                        PORT_CPU: begin
                            mem_we    <= cpu_we;
                            mem_addr  <= cpu_addr;
                            mem_wdata <= cpu_wdata;
                            mem_dqm   <= ~cpu_bytesel;
                            streak    <= '0;
                            rr_ptr    <= other_general(PORT_CPU);
                        end
                        PORT_JTAG: begin
                            mem_we    <= jtag_we;
                            mem_addr  <= jtag_addr;
                            mem_wdata <= jtag_wdata;
                            mem_dqm   <= ~jtag_bytesel;
                            streak    <= '0;
                            rr_ptr    <= other_general(PORT_JTAG);
                        end
                        default: ;
                    endcase
                end
                ISSUE: begin
                    if (mem_ack) rdata <= mem_rdata;
                end
                RESP: begin
                    grant <= PORT_NONE;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Self-checking bench: controller model, per-port drivers and an ack scoreboard.
module tb_sdram_port_arbiter;
    import sdram_arb_pkg::*;

    localparam int AW = 24;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          vid_req, cpu_req, cpu_we, jtag_req, jtag_we;
    logic [AW-1:0] vid_addr, cpu_addr, jtag_addr;
    logic [DW-1:0] cpu_wdata, jtag_wdata;
    logic [1:0]    cpu_bytesel, jtag_bytesel;
    logic          vid_ack, cpu_ack, jtag_ack;
    logic [DW-1:0] rdata;
    logic          mem_req, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [1:0]    mem_dqm;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;
    logic [1:0]    grant_id;
    logic          protocol_err;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          mack_cyc = -10;
    int          ack_delay = 0;
    int          ctrl_cnt = 0;
    int          stray_req = 0;
    int          stray_done = 0;
    logic [17:0] exp_q[$];

    sdram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .VIDEO_MAX(4)) dut (
        .clk(clk), .reset(reset),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_bytesel(cpu_bytesel), .cpu_ack(cpu_ack),
        .jtag_req(jtag_req), .jtag_we(jtag_we), .jtag_addr(jtag_addr), .jtag_wdata(jtag_wdata),
        .jtag_bytesel(jtag_bytesel), .jtag_ack(jtag_ack),
        .rdata(rdata), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_dqm(mem_dqm), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .grant_id(grant_id), .protocol_err(protocol_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] model_rdata(input logic [AW-1:0] a);
        return a[15:0] ^ 16'hACDB;
    endfunction

    function automatic logic ack_of(input port_id_t p);
        case (p)
            PORT_VID:  return vid_ack;
            PORT_CPU:  return cpu_ack;
            PORT_JTAG: return jtag_ack;
            default:   return 1'b0;
        endcase
    endfunction

    // Controller model: acks ack_delay cycles after mem_req rises, junk on mem_rdata otherwise.
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_ack   = 1'b0;
            mem_rdata = DW'($urandom);
            if (stray_req != stray_done) begin
                mem_ack    = 1'b1;
                stray_done = stray_req;
            end else if (mem_req) begin
                if (ctrl_cnt >= ack_delay) begin
                    mem_ack   = 1'b1;
                    mem_rdata = model_rdata(mem_addr);
                    ctrl_cnt  = 0;
                end else begin
                    ctrl_cnt++;
                end
            end else begin
                ctrl_cnt = 0;
            end
        end
    end

    // Scoreboard: every port ack pops the next expected {port, rdata}.
    initial begin
        logic [1:0]  id;
        logic [17:0] e;
        int          n;
        forever begin
            @(posedge clk);
            #2;
            n = int'(vid_ack) + int'(cpu_ack) + int'(jtag_ack);
            if (n > 0) begin
                check("ack_onehot", n, 1);
                id = vid_ack ? 2'd1 : (cpu_ack ? 2'd2 : 2'd3);
                if (exp_q.size() == 0) begin
                    check("ack_unexpected", {30'd0, id}, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("ack_port", {30'd0, id}, {30'd0, e[17:16]});
                    check("ack_rdata", {16'd0, rdata}, {16'd0, e[15:0]});
                    check("ack_latency", cyc - mack_cyc, 1);
                end
            end
            if (mem_ack) mack_cyc = cyc;
        end
    end

    task automatic check_outputs_zero();
        check("rst_vid_ack", vid_ack, 0);
        check("rst_cpu_ack", cpu_ack, 0);
        check("rst_jtag_ack", jtag_ack, 0);
        check("rst_rdata", rdata, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_mem_dqm", mem_dqm, 0);
        check("rst_grant_id", grant_id, 0);
        check("rst_protocol_err", protocol_err, 0);
    endtask

    task automatic run_txn(input port_id_t p, input logic we, input logic [AW-1:0] a,
                           input logic [DW-1:0] wd, input logic [1:0] bs);
        int         t;
        logic [1:0] dqm_exp;
        dqm_exp = ~bs;
        if (p == PORT_CPU) begin
            cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd; cpu_bytesel = bs;
        end else begin
            jtag_req = 1'b1; jtag_we = we; jtag_addr = a; jtag_wdata = wd; jtag_bytesel = bs;
        end
        exp_q.push_back({2'(p), model_rdata(a)});
        t = 0;
        while (!mem_req && t < 50) begin @(posedge clk); #1; t++; end
        check("mem_req_seen", mem_req, 1);
        check("grant_id_busy", grant_id, 2'(p));
        check("mem_addr", mem_addr, a);
        check("mem_we", mem_we, we);
        check("mem_dqm", mem_dqm, dqm_exp);
        if (we) check("mem_wdata", mem_wdata, wd);
        // Inputs wander during service; the issued command must not follow them.
        if (p == PORT_CPU) begin
            cpu_addr = AW'($urandom); cpu_wdata = DW'($urandom); cpu_we = ~we;
        end else begin
            jtag_addr = AW'($urandom); jtag_wdata = DW'($urandom); jtag_we = ~we;
        end
        t = 0;
        while (!ack_of(p) && t < 50) begin @(posedge clk); #1; t++; end
        check("port_ack_seen", ack_of(p), 1);
        check("mem_addr_held", mem_addr, a);
        check("mem_we_held", mem_we, we);
        if (p == PORT_CPU) cpu_req = 1'b0; else jtag_req = 1'b0;
        @(posedge clk);
        #1;
        check("grant_id_idle", grant_id, 0);
        check("mem_req_idle", mem_req, 0);
    endtask

    task automatic wait_acks(input int n, input int gap);
        int count;
        int prev;
        int t;
        count = 0; prev = -1; t = 0;
        while (count < n && t < 300) begin
            @(posedge clk);
            #1;
            t++;
            if (mem_req && grant_id == 2'd1) begin
                check("vid_mem_we", mem_we, 0);
                check("vid_mem_wdata", mem_wdata, 0);
                check("vid_mem_dqm", mem_dqm, 0);
            end
            if (vid_ack | cpu_ack | jtag_ack) begin
                count++;
                if (gap > 0 && prev >= 0) check("ack_gap", cyc - prev, gap);
                prev = cyc;
            end
        end
        check("acks_seen", count, n);
    endtask

    initial begin
        vid_req = 0; vid_addr = '0;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0; cpu_bytesel = 2'b11;
        jtag_req = 0; jtag_we = 0; jtag_addr = '0; jtag_wdata = '0; jtag_bytesel = 2'b11;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero();
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Single CPU read, controller answers three cycles after mem_req.
        ack_delay = 3;
        run_txn(PORT_CPU, 1'b0, 24'h001234, 16'h0000, 2'b11);
        // CPU write with only the low byte enabled.
        ack_delay = 1;
        run_txn(PORT_CPU, 1'b1, 24'h00ABCD, 16'hA55A, 2'b01);
        for (int i = 0; i < 4; i++) begin
            ack_delay = $urandom_range(0, 4);
            run_txn(($urandom_range(0, 1) == 0) ? PORT_CPU : PORT_JTAG, 1'($urandom_range(0, 1)),
                    AW'($urandom), DW'($urandom), 2'($urandom_range(0, 3)));
        end

        // Stray controller ack while idle.
        stray_req++;
        repeat (2) begin @(posedge clk); #1; end
        check("stray_protocol_err", protocol_err, 1);
        check("stray_grant_id", grant_id, 0);
        run_txn(PORT_CPU, 1'b0, 24'h000042, 16'h0000, 2'b11);
        check("protocol_err_sticky", protocol_err, 1);

        // Reset pulse in IDLE returns rr_ptr to CPU and clears the sticky error.
        reset = 1'b1;
        #1;
        check("protocol_err_cleared", protocol_err, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Round-robin with both general ports held and immediate acks.
        ack_delay = 0;
        cpu_req = 1; cpu_we = 0; cpu_addr = 24'h000100; cpu_bytesel = 2'b11;
        jtag_req = 1; jtag_we = 0; jtag_addr = 24'h000200; jtag_bytesel = 2'b11;
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back({2'd2, model_rdata(24'h000100)});
            exp_q.push_back({2'd3, model_rdata(24'h000200)});
        end
        wait_acks(4, 3);
        cpu_req = 0; jtag_req = 0;
        repeat (2) begin @(posedge clk); #1; end
        check("rr_idle_grant", grant_id, 0);

        // Video starvation bound against a held CPU write, then video alone.
        ack_delay = 1;
        vid_req = 1; vid_addr = 24'h003000;
        cpu_req = 1; cpu_we = 1; cpu_addr = 24'h000300; cpu_wdata = 16'h1357; cpu_bytesel = 2'b10;
        for (int r = 0; r < 2; r++) begin
            for (int v = 0; v < 4; v++) exp_q.push_back({2'd1, model_rdata(24'h003000)});
            exp_q.push_back({2'd2, model_rdata(24'h000300)});
        end
        wait_acks(10, 0);
        cpu_req = 0;
        for (int v = 0; v < 3; v++) exp_q.push_back({2'd1, model_rdata(24'h003000)});
        wait_acks(3, 0);
        vid_req = 0;
        repeat (2) begin @(posedge clk); #1; end

        // Reset while the CPU transaction sits in ISSUE, with JTAG pending.
        ack_delay = 10;
        cpu_req = 1; cpu_we = 0; cpu_addr = 24'h000777; cpu_bytesel = 2'b11;
        repeat (2) begin @(posedge clk); #1; end
        check("pre_reset_mem_req", mem_req, 1);
        check("pre_reset_grant", grant_id, 2);
        jtag_req = 1; jtag_we = 0; jtag_addr = 24'h000888; jtag_bytesel = 2'b11;
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check_outputs_zero();
        cpu_req = 0;
        @(posedge clk);
        #1;
        check("reset_hold_mem_req", mem_req, 0);
        reset = 1'b0;
        run_txn(PORT_JTAG, 1'b0, 24'h000888, 16'h0000, 2'b11);

        repeat (5) begin @(posedge clk); #1; end
        check("exp_q_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
- Shares one SDRAM controller request/ack port between three requesters: video fetch (read-only), CPU, and JTAG debug bridge.
- Sits between the jtagdemo core and the SDRAM controller, in the sysclk domain.
- Video has bounded priority; CPU and JTAG alternate round-robin.
- One transaction is outstanding at a time.

Parameters:
- ADDR_WIDTH, 24, word address width on all ports.
- DATA_WIDTH, 16, data width (matches SDRAM_DQ).
- VIDEO_MAX, 4, maximum consecutive video grants while a CPU/JTAG request waits; legal range is ≥1.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
vid_req  in  1  video read request; held until vid_ack
vid_addr  in  ADDR_WIDTH  video read address
vid_ack  out  1  one-cycle completion pulse, video
cpu_req  in  1  CPU request; held until cpu_ack
cpu_we  in  1  CPU write (1) / read (0)
cpu_addr  in  ADDR_WIDTH  CPU address
cpu_wdata  in  DATA_WIDTH  CPU write data
cpu_bytesel  in  2  CPU byte enables, [1]=high byte
cpu_ack  out  1  one-cycle completion pulse, CPU
jtag_req, jtag_we, jtag_addr, jtag_wdata, jtag_bytesel  in  as CPU  JTAG bridge request signals
jtag_ack  out  1  one-cycle completion pulse, JTAG
rdata  out  DATA_WIDTH  read data; valid in any ack cycle
mem_req  out  1  request to SDRAM controller; held until mem_ack
mem_we  out  1  write strobe to controller
mem_addr  out  ADDR_WIDTH  address to controller
mem_wdata  out  DATA_WIDTH  write data to controller
mem_dqm  out  2  active-high byte masks (~bytesel); 2'b00 for video
mem_ack  in  1  controller completion pulse; mem_rdata valid in the same cycle
mem_rdata  in  DATA_WIDTH  controller read data
grant_id  out  2  port currently in service: 0 none, 1 VID, 2 CPU, 3 JTAG
protocol_err  out  1  sticky; set on mem_ack outside ISSUE

Behaviour:
- Reset values: all outputs 0. This includes mem_dqm=2'b00, rdata=0, grant_id=0, protocol_err=0, streak=0, rr_ptr=CPU.
- Reset asserted mid-transaction abandons it with no ack. The controller is reset on the same reset.
- FSM states:
  - IDLE: evaluate requests; on a winner, register the mem_* signals and grant_id, then go to ISSUE. No winner: stay in IDLE.
  - ISSUE: mem_req=1 with the other mem_* signals stable. Stay until mem_ack, then latch mem_rdata into rdata and go to RESP.
  - RESP: assert the granted port's ack for exactly one cycle; mem_req=0; return to IDLE. grant_id clears to 0 on entering IDLE.
- Requesters drop req on the clock edge after seeing ack. IDLE therefore never re-serves a stale request.
- Latency: req sampled in cycle 0 gives mem_req in cycle 1. mem_ack in cycle k (k≥1) gives the port ack in cycle k+1. Minimum req-to-ack is 2 cycles; back-to-back service takes 3 cycles per transaction.
- Selection in IDLE:
  - gen_pending = cpu_req|jtag_req.
  - Video wins if vid_req and (!gen_pending or streak<VIDEO_MAX).
  - Otherwise the general winner is chosen by rr_ptr. If both CPU and JTAG request, rr_ptr's port wins. If only one requests, that one wins.
  - rr_ptr toggles to the other port after every general grant.
- Streak counter (saturating, width clog2(VIDEO_MAX+1)):
  - Increments on a video grant while gen_pending.
  - Clears on any general grant.
  - Clears on a video grant with !gen_pending.
- Video is always a read: mem_we=0, mem_wdata=0.
- Inputs are sampled only in IDLE. Changes to addr/data/we while a request is in service are ignored.
- mem_ack in IDLE or RESP: ignored for data, sets protocol_err. Only reset clears protocol_err.
- Reads and writes both complete with ack. rdata is undefined-but-stable for writes (holds mem_rdata as sampled).
- Address and data pass through with no width conversion.

Decomposition:
- Package sdram_arb_pkg:
  - port_id_t enum: PORT_NONE=0, PORT_VID=1, PORT_CPU=2, PORT_JTAG=3.
  - arb_state_t enum: IDLE, ISSUE, RESP.
- One sub-module, sdram_arb_pick: combinational winner selection from vid_req, cpu_req, jtag_req, streak, VIDEO_MAX and rr_ptr. Returns port_id_t.
- The FSM, registers and output muxing stay in sdram_port_arbiter.

Test Plan:
1. Single CPU read: cpu_req=1, addr=0x001234, controller acks 3 cycles after mem_req with rdata 0xBEEF.
   - Required: mem_addr=0x001234, mem_we=0, mem_dqm=00.
   - Required: cpu_ack one cycle after mem_ack, with rdata=0xBEEF.
   - Required: grant_id=2 during service, 0 afterwards.
2. CPU write with byte enables: cpu_we=1, wdata=0xA55A, bytesel=2'b01.
   - Required: mem_we=1, mem_wdata=0xA55A, mem_dqm=2'b10.
   - Required: no other ack pulses.
3. Round-robin: cpu_req and jtag_req held continuously, controller acks immediately.
   - Required: grant order CPU, JTAG, CPU, JTAG, with one ack every 3 cycles.
4. Video starvation bound: vid_req and cpu_req held continuously, VIDEO_MAX=4.
   - Required: grants repeat V,V,V,V,C.
   - Required: video alone (cpu_req=0) is granted every transaction.
5. Stray ack: pulse mem_ack while in IDLE.
   - Required: protocol_err=1 and stays 1; no port ack; the next CPU transaction completes normally.
6. Reset mid-ISSUE: assert reset while mem_req=1.
   - Required: all outputs 0 immediately (asynchronous), no ack produced.
   - Required: after release, pending jtag_req is served first because rr_ptr reset to CPU and cpu_req=0.
